// File: rtl/hazard_sb.sv
// Scoreboard-based hazard/forwarding unit: tracks in-flight instructions E..W and derives stalls, flushes and E-stage forward selects.
// Optional ARM behaviour (live r0, r15 never forwarded, PC-write pending) is enabled by defining HAZARD_SB_ARM_EN.
module hazard_sb #(
    parameter int REGS     = 32,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    localparam int AW      = $clog2(REGS),
    localparam int FW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          issue_valid,
    input  logic [AW-1:0] rs1_d,
    input  logic [AW-1:0] rs2_d,
    input  logic          rs1_used_d,
    input  logic          rs2_used_d,
    input  logic [AW-1:0] rd_d,
    input  logic          we_d,
    input  logic          load_d,
    input  logic          pcw_d,
    input  logic          redirect_e,
    input  logic          mem_ready,
    output logic          stall_f,
    output logic          stall_d,
    output logic          flush_d,
    output logic          flush_e,
    output logic          stall_be,
    output logic [FW-1:0] fwd_a,
    output logic [FW-1:0] fwd_b
);

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] we_reg;
    logic [DEPTH-1:0] load_reg;
    logic [AW-1:0]    rd_reg [DEPTH];
    logic [AW-1:0]    rs1_reg;
    logic [AW-1:0]    rs2_reg;
    logic [DEPTH-1:0] live;
    logic             arm_eff;
    logic             pcw_pend;
    logic             lu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            we_reg    <= '0;
            load_reg  <= '0;
            rs1_reg   <= '0;
            rs2_reg   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd_reg[k] <= '0;
            end
        end else if (mem_ready) begin
            valid_reg[0] <= issue_valid & ~flush_e;
            we_reg[0]    <= we_d;
            load_reg[0]  <= load_d;
            rd_reg[0]    <= rd_d;
            rs1_reg      <= rs1_d;
            rs2_reg      <= rs2_d;
            for (int k = 1; k < DEPTH; k++) begin
                valid_reg[k] <= valid_reg[k-1];
                we_reg[k]    <= we_reg[k-1];
                load_reg[k]  <= load_reg[k-1];
                rd_reg[k]    <= rd_reg[k-1];
            end
        end
    end

`ifdef HAZARD_SB_ARM_EN
    logic [DEPTH-1:0] pcw_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcw_reg <= '0;
        end else if (mem_ready) begin
            pcw_reg <= {pcw_reg[DEPTH-2:0], pcw_d};
        end
    end

    assign arm_eff = arm;
    // The writer in W releases fetch so the new PC can load.
    assign pcw_pend = arm & |(pcw_reg[DEPTH-2:0] & valid_reg[DEPTH-2:0]);
`else
    logic unused_ok;
    assign unused_ok = ^{arm, pcw_d};
    assign arm_eff   = 1'b0;
    assign pcw_pend  = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_live
            assign live[gi] = valid_reg[gi] & we_reg[gi] & (arm_eff | (rd_reg[gi] != '0));
        end
    endgenerate

    // Loads younger than LOAD_LAT-1 cannot be forwarded in time for the decode consumer.
    always_comb begin
        lu = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((k < LOAD_LAT - 1) && live[k] && load_reg[k] &&
                ((rs1_used_d && (rs1_d == rd_reg[k])) || (rs2_used_d && (rs2_d == rd_reg[k])))) begin
                lu = 1'b1;
            end
        end
        lu = lu & issue_valid;
    end

    // Scan oldest to youngest so the nearest producer wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (live[k] && (!load_reg[k] || k >= LOAD_LAT)) begin
                if (rd_reg[k] == rs1_reg) fwd_a = FW'(k);
                if (rd_reg[k] == rs2_reg) fwd_b = FW'(k);
            end
        end
        if (arm_eff && (rs1_reg == AW'(15))) fwd_a = '0;
        if (arm_eff && (rs2_reg == AW'(15))) fwd_b = '0;
    end

    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        stall_be = 1'b0;
        if (!rst) begin
            if (!mem_ready) begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                stall_be = 1'b1;
            end else begin
                if (redirect_e) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (lu) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
                if (pcw_pend) begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end
            end
        end
    end

endmodule
